mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback-select logic for the 5-stage MIPS pipeline.
- Captures memory-stage results on each clock and drives WriteRegister / WriteData / RegWrite.
- These outputs feed the register file write port and the writeback forwarding unit in the decode stage.
- Provides stall (hold), flush (bubble insert) and a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, width of ALU result, memory read data, link address and WriteData
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
Stall  input  1  hold all MEM/WB state this cycle
Flush  input  1  replace incoming MEM instruction with a bubble
ValidM  input  1  MEM stage holds a real instruction
RegWriteM  input  1  instruction writes a register
MemtoRegM  input  1  writeback data comes from memory read data
LinkM  input  1  jal/jalr: write link address to $31
WriteRegisterM  input  5  destination register from MEM
ALUResultM  input  DATA_WIDTH  ALU result from MEM
MemReadDataM  input  DATA_WIDTH  data memory read data
LinkAddrM  input  DATA_WIDTH  precomputed PC+8 for link writes
WriteRegister  output  5  register file / forwarding write address
WriteData  output  DATA_WIDTH  register file / forwarding write data
RegWrite  output  1  qualified write enable
ValidW  output  1  WB stage holds a real instruction
RetireCount  output  CNT_WIDTH  instructions retired since reset

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.

Internal registers:
- valid_q, regwrite_q, memtoreg_q, link_q, wreg_q[4:0], alu_q, mem_q, link_addr_q.

Update priority at each rising edge (highest first):
1. reset:
   - All internal registers and RetireCount cleared to 0.
   - Resulting outputs: RegWrite=0, WriteRegister=0, WriteData=0, ValidW=0.
2. Flush:
   - valid_q, regwrite_q, memtoreg_q and link_q cleared.
   - wreg_q and data registers cleared to 0.
   - Flush beats Stall when both are high.
3. Stall:
   - All MEM/WB registers hold their values.
   - The held instruction keeps driving its write, which is idempotent.
4. Otherwise: capture all M-side inputs into the matching registers. valid_q takes ValidM.

Output logic (combinational from registers, zero added latency after capture):
- WriteRegister = link_q ? 5'd31 : wreg_q
- WriteData = link_q ? link_addr_q : (memtoreg_q ? mem_q : alu_q). Link has priority over MemtoReg.
- RegWrite = valid_q & (regwrite_q | link_q) & (WriteRegister != 0). Writes to $0 are never asserted.
- ValidW = valid_q

Latency:
- An M-side instruction presented in cycle N appears on the W-side outputs after the edge ending cycle N.
- Outputs are stable throughout cycle N+1.

RetireCount:
- Increments by 1 at an edge where valid_q=1, Stall=0 and reset=0.
- Flush does not suppress it, since flush kills only the incoming instruction, not the one in WB.
- A stalled instruction is counted exactly once, on the edge it leaves.
- Wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Boundary conditions:
- reset asserted mid-stall or mid-flush: reset wins, everything cleared.
- ValidM=0 with RegWriteM=1: captured, but RegWrite stays 0 because valid_q=0.
- Link with WriteRegisterM=0: WriteRegister forced to 31, so RegWrite is still asserted.
- Stall released: the next edge captures the current M inputs normally.

Test Plan:
- Reset:
  - Stimulus: assert reset for 2 cycles with all inputs at garbage values.
  - Required: all outputs 0 and RetireCount=0. The first capture after deassertion passes through.
- Writeback select:
  - ALU case: ValidM=1, RegWriteM=1, MemtoRegM=0, WriteRegisterM=8, ALUResultM=0x12345678. Next cycle: WriteRegister=8, WriteData=0x12345678, RegWrite=1.
  - Load case: same with MemtoRegM=1, MemReadDataM=0xDEADBEEF. Next cycle: WriteData=0xDEADBEEF.
- Link and $0:
  - Link: LinkM=1, LinkAddrM=0x00400010, MemtoRegM=1, WriteRegisterM=0. Required: WriteRegister=31, WriteData=0x00400010, RegWrite=1.
  - $0 write: RegWriteM=1, WriteRegisterM=0, LinkM=0. Required: RegWrite=0.
- Stall/flush:
  - Stall for 3 cycles while M inputs change. Required: outputs frozen on the first instruction.
  - Assert Stall and Flush together. Required: bubble captured, RegWrite=0, ValidW=0.
- Retire counter:
  - Sequence of 5 valid instructions with one 2-cycle stall and one flush bubble. Required: RetireCount=5, not 7.
  - Preload the counter near 0xFFFFFFFF by driving 2^32 retires in sim, or with CNT_WIDTH=4 driving 16 retires. Required: wraps to 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback-select and retired-instruction counter.
// Feeds the register-file write port and the decode-stage forwarding unit.
module mem_wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  LinkM,
  input  logic [4:0]            WriteRegisterM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] MemReadDataM,
  input  logic [DATA_WIDTH-1:0] LinkAddrM,
  output logic [4:0]            WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite,
  output logic                  ValidW,
  output logic [CNT_WIDTH-1:0]  RetireCount
);

  logic                  valid_q, valid_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  link_q, link_d;
  logic [4:0]            wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] mem_q, mem_d;
  logic [DATA_WIDTH-1:0] link_addr_q, link_addr_d;
  logic [CNT_WIDTH-1:0]  retire_q, retire_d;

  // Flush outranks Stall: the bubble replaces whatever M presents.
  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    link_d      = link_q;
    wreg_d      = wreg_q;
    alu_d       = alu_q;
    mem_d       = mem_q;
    link_addr_d = link_addr_q;
    if (Flush) begin
      valid_d     = 1'b0;
      regwrite_d  = 1'b0;
      memtoreg_d  = 1'b0;
      link_d      = 1'b0;
      wreg_d      = '0;
      alu_d       = '0;
      mem_d       = '0;
      link_addr_d = '0;
    end else if (!Stall) begin
      valid_d     = ValidM;
      regwrite_d  = RegWriteM;
      memtoreg_d  = MemtoRegM;
      link_d      = LinkM;
      wreg_d      = WriteRegisterM;
      alu_d       = ALUResultM;
      mem_d       = MemReadDataM;
      link_addr_d = LinkAddrM;
    end
  end

  // The WB instruction retires on the edge it leaves; a flush only kills the incoming one.
  always_comb begin
    retire_d = retire_q;
    if (valid_q && !Stall) retire_d = retire_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      link_q      <= 1'b0;
      wreg_q      <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      link_addr_q <= '0;
      retire_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      link_q      <= link_d;
      wreg_q      <= wreg_d;
      alu_q       <= alu_d;
      mem_q       <= mem_d;
      link_addr_q <= link_addr_d;
      retire_q    <= retire_d;
    end
  end

  always_comb begin
    WriteRegister = link_q ? 5'd31 : wreg_q;
    WriteData     = link_q ? link_addr_q : (memtoreg_q ? mem_q : alu_q);
    RegWrite      = valid_q & (regwrite_q | link_q) & (WriteRegister != 5'd0);
    ValidW        = valid_q;
    RetireCount   = retire_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a 4-bit-counter copy shares the stimulus to show wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush, ValidM, RegWriteM, MemtoRegM, LinkM;
  logic [4:0]  WriteRegisterM;
  logic [31:0] ALUResultM, MemReadDataM, LinkAddrM;
  logic [4:0]  WriteRegister, WriteRegister4;
  logic [31:0] WriteData, WriteData4;
  logic        RegWrite, RegWrite4, ValidW, ValidW4;
  logic [31:0] RetireCount;
  logic [3:0]  RetireCount4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LinkM(LinkM),
    .WriteRegisterM(WriteRegisterM), .ALUResultM(ALUResultM),
    .MemReadDataM(MemReadDataM), .LinkAddrM(LinkAddrM),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ValidW(ValidW), .RetireCount(RetireCount)
  );

  mem_wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .LinkM(LinkM),
    .WriteRegisterM(WriteRegisterM), .ALUResultM(ALUResultM),
    .MemReadDataM(MemReadDataM), .LinkAddrM(LinkAddrM),
    .WriteRegister(WriteRegister4), .WriteData(WriteData4), .RegWrite(RegWrite4),
    .ValidW(ValidW4), .RetireCount(RetireCount4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic [4:0] wr, input logic [31:0] wd,
                        input logic rw, input logic vw);
    chk({tag, ".WriteRegister"}, {27'd0, WriteRegister}, {27'd0, wr});
    chk({tag, ".WriteData"},     WriteData,              wd);
    chk({tag, ".RegWrite"},      {31'd0, RegWrite},      {31'd0, rw});
    chk({tag, ".ValidW"},        {31'd0, ValidW},        {31'd0, vw});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] c32, input logic [3:0] c4);
    chk({tag, ".RetireCount"},  RetireCount,           c32);
    chk({tag, ".RetireCount4"}, {28'd0, RetireCount4}, {28'd0, c4});
  endtask

  task automatic set_m(input logic v, input logic rw, input logic m2r, input logic lk,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] mrd, input logic [31:0] la);
    ValidM = v; RegWriteM = rw; MemtoRegM = m2r; LinkM = lk;
    WriteRegisterM = wr; ALUResultM = alu; MemReadDataM = mrd; LinkAddrM = la;
  endtask

  initial begin
    // Reset with garbage on every input, including Stall and Flush
    reset = 1'b1; Stall = 1'b1; Flush = 1'b0;
    set_m(1, 1, 1, 1, 5'd17, 32'hFFFF_0000, 32'h1111_2222, 32'h3333_4444);
    step(2);
    chk_wb("reset", 5'd0, 32'd0, 1'b0, 1'b0);
    chk_cnt("reset", 32'd0, 4'd0);

    // ALU writeback
    reset = 1'b0; Stall = 1'b0;
    set_m(1, 1, 0, 0, 5'd8, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0BAD);
    step();
    chk_wb("alu", 5'd8, 32'h1234_5678, 1'b1, 1'b1);
    chk_cnt("alu", 32'd0, 4'd0);

    // Load writeback
    MemtoRegM = 1'b1;
    step();
    chk_wb("load", 5'd8, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk_cnt("load", 32'd1, 4'd1);

    // Link to $0 destination is redirected to $31 and beats MemtoReg
    set_m(1, 0, 1, 1, 5'd0, 32'h0000_00AA, 32'h0000_00BB, 32'h0040_0010);
    step();
    chk_wb("link", 5'd31, 32'h0040_0010, 1'b1, 1'b1);

    // Plain write to $0 is never asserted
    set_m(1, 1, 0, 0, 5'd0, 32'h0000_0055, 32'h0, 32'h0);
    step();
    chk_wb("zero", 5'd0, 32'h0000_0055, 1'b0, 1'b1);
    chk_cnt("zero", 32'd3, 4'd3);

    // Invalid instruction with RegWriteM set
    set_m(0, 1, 0, 0, 5'd9, 32'h0000_0077, 32'h0, 32'h0);
    step();
    chk_wb("invalid", 5'd9, 32'h0000_0077, 1'b0, 1'b0);
    chk_cnt("invalid", 32'd4, 4'd4);

    // Stall 3 cycles while M changes; WB stays frozen and uncounted
    set_m(1, 1, 0, 0, 5'd10, 32'hA0A0_A0A0, 32'h0, 32'h0);
    step();
    chk_wb("pre_stall", 5'd10, 32'hA0A0_A0A0, 1'b1, 1'b1);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1, 0, 0, 5'd11 + 5'(i), 32'h0000_BB00 + i, 32'h0, 32'h0);
      step();
      chk_wb($sformatf("stall%0d", i), 5'd10, 32'hA0A0_A0A0, 1'b1, 1'b1);
      chk_cnt($sformatf("stall%0d", i), 32'd4, 4'd4);
    end

    // Release: current M inputs captured, stalled instruction counted once
    Stall = 1'b0;
    step();
    chk_wb("unstall", 5'd13, 32'h0000_BB02, 1'b1, 1'b1);
    chk_cnt("unstall", 32'd5, 4'd5);

    // Stall and Flush together: bubble wins, no retire since Stall is high
    Stall = 1'b1; Flush = 1'b1;
    step();
    chk_wb("stall_flush", 5'd0, 32'd0, 1'b0, 1'b0);
    chk_cnt("stall_flush", 32'd5, 4'd5);

    // Flush alone still retires the instruction already in WB
    Stall = 1'b0; Flush = 1'b0;
    set_m(1, 1, 0, 0, 5'd12, 32'h0000_000C, 32'h0, 32'h0);
    step();
    chk_wb("pre_flush", 5'd12, 32'h0000_000C, 1'b1, 1'b1);
    Flush = 1'b1;
    step();
    chk_wb("flush", 5'd0, 32'd0, 1'b0, 1'b0);
    chk_cnt("flush", 32'd6, 4'd6);

    // Reset in the middle of a stall with a valid instruction in WB
    Flush = 1'b0;
    step();
    Stall = 1'b1; reset = 1'b1;
    step();
    chk_wb("reset_mid_stall", 5'd0, 32'd0, 1'b0, 1'b0);
    chk_cnt("reset_mid_stall", 32'd0, 4'd0);

    // 5 valid instructions, one 2-cycle stall, one flush bubble
    reset = 1'b0; Stall = 1'b0;
    set_m(1, 1, 0, 0, 5'd1, 32'd1, 32'd0, 32'd0); step();
    set_m(1, 1, 0, 0, 5'd2, 32'd2, 32'd0, 32'd0); step();
    Stall = 1'b1; step(2);
    Stall = 1'b0;
    set_m(1, 1, 0, 0, 5'd3, 32'd3, 32'd0, 32'd0); step();
    Flush = 1'b1; step();
    Flush = 1'b0;
    set_m(1, 1, 0, 0, 5'd4, 32'd4, 32'd0, 32'd0); step();
    set_m(1, 1, 0, 0, 5'd5, 32'd5, 32'd0, 32'd0); step();
    chk_wb("seq_last", 5'd5, 32'd5, 1'b1, 1'b1);
    ValidM = 1'b0; step();
    step();
    chk_cnt("seq", 32'd5, 4'd5);

    // 11 more retires take the 4-bit counter through its wrap
    ValidM = 1'b1;
    step(12);
    chk_cnt("wrap", 32'd16, 4'd0);
    step();
    chk_cnt("post_wrap", 32'd17, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
